// File: rtl/lsu_axi_master.sv
// Load/store unit bus master: one EX request at a time onto an AXI-lite data port,
// with byte-lane placement for stores and lane extraction plus sign/zero extension for loads.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // EX/MEM request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  // WB response
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  // AXI-lite read
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  // AXI-lite write
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_D, S_WR, S_WR_B, S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic                r_aw_done;
  logic                r_w_done;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;

  logic                w_misaligned;
  logic [STRB_W-1:0]   w_strb_base;
  logic [DATA_W-1:0]   w_rd_shift;
  logic [DATA_W-1:0]   w_load_ext;
  logic                w_aw_ok;
  logic                w_w_ok;

  assign w_misaligned = (req_size == 2'd3) ||
                        (req_size == 2'd1 && req_addr[0]) ||
                        (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  always_comb begin
    case (req_size)
      2'd0:    w_strb_base = STRB_W'(4'b0001);
      2'd1:    w_strb_base = STRB_W'(4'b0011);
      default: w_strb_base = STRB_W'(4'b1111);
    endcase
  end

  // Loads: bring the addressed lane down to bit 0, then extend to full width.
  assign w_rd_shift = rdata >> {r_addr[OFF_W-1:0], 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_load_ext = r_unsigned ? {{(DATA_W-8){1'b0}}, w_rd_shift[7:0]}
                                       : {{(DATA_W-8){w_rd_shift[7]}}, w_rd_shift[7:0]};
      2'd1:    w_load_ext = r_unsigned ? {{(DATA_W-16){1'b0}}, w_rd_shift[15:0]}
                                       : {{(DATA_W-16){w_rd_shift[15]}}, w_rd_shift[15:0]};
      default: w_load_ext = rdata;
    endcase
  end

  assign req_ready  = (r_state == S_IDLE);
  assign arvalid    = (r_state == S_RD_A);
  assign rready     = (r_state == S_RD_D);
  assign awvalid    = (r_state == S_WR) && !r_aw_done;
  assign wvalid     = (r_state == S_WR) && !r_w_done;
  assign bready     = (r_state == S_WR_B);
  assign resp_valid = (r_state == S_RESP);
  assign araddr     = r_addr;
  assign awaddr     = r_addr;
  assign wdata      = r_wdata;
  assign wstrb      = r_wstrb;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  // AW and W complete independently; either may finish in the same cycle as the other.
  assign w_aw_ok = r_aw_done || (awvalid && awready);
  assign w_w_ok  = r_w_done  || (wvalid && wready);

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_misaligned ? S_RESP : (req_we ? S_WR : S_RD_A);
      S_RD_A: if (arready)   w_next = S_RD_D;
      S_RD_D: if (rvalid)    w_next = S_RESP;
      S_WR:   if (w_aw_ok && w_w_ok) w_next = S_WR_B;
      S_WR_B: if (bvalid)    w_next = S_RESP;
      S_RESP: if (resp_ready) w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr       <= req_addr;
          r_wdata      <= req_wdata << {req_addr[OFF_W-1:0], 3'b000};
          r_wstrb      <= w_strb_base << req_addr[OFF_W-1:0];
          r_size       <= req_size;
          r_unsigned   <= req_unsigned;
          r_aw_done    <= 1'b0;
          r_w_done     <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= w_misaligned;
        end
        S_RD_D: if (rvalid) begin
          r_resp_rdata <= (rresp != 2'b00) ? '0 : w_load_ext;
          r_resp_err   <= (rresp != 2'b00);
        end
        S_WR: begin
          if (awvalid && awready) r_aw_done <= 1'b1;
          if (wvalid && wready)   r_w_done  <= 1'b1;
        end
        S_WR_B: if (bvalid) r_resp_err <= (bresp != 2'b00);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Randomized scoreboard bench for lsu_axi_master: byte-array reference model,
// responsive AXI-lite slave with its own word memory, and a decoupled response monitor.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  typedef struct { logic [31:0] d; logic [1:0] resp; } rd_t;

  logic [7:0]  mem_m [64];
  logic [31:0] mem_s [16];
  resp_t       resp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ar_q[$];

  // Slave answers SLVERR for anything in the 0x...1xxx window.
  function automatic bit err_region(input logic [31:0] a);
    return (a & 32'h0000_1000) != 0;
  endfunction

  function automatic bit is_misaligned(input int size, input logic [31:0] a);
    return (size == 3) || ((a % (1 << size)) != 0);
  endfunction

  task automatic set_word(input int idx, input logic [31:0] v);
    mem_s[idx] = v;
    for (int i = 0; i < 4; i++) mem_m[idx*4 + i] = v[i*8 +: 8];
  endtask

  task automatic model_request(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input int size, input logic uns);
    resp_t r;
    wr_t   w;
    int    n, off, b;
    logic [63:0] t;
    longint v;
    n = 1 << size;
    off = addr % 4;
    b = addr % 64;
    r.rdata = 32'h0;
    r.err = 1'b0;
    if (is_misaligned(size, addr)) begin
      r.err = 1'b1;
    end else if (we) begin
      w.addr = addr;
      t = {32'h0, wd};
      t = t << (8 * off);
      w.data = t[31:0];
      w.strb = 4'h0;
      for (int i = 0; i < n; i++) w.strb[off + i] = 1'b1;
      wr_q.push_back(w);
      if (err_region(addr)) r.err = 1'b1;
      else for (int i = 0; i < n; i++) mem_m[b + i] = wd[i*8 +: 8];
    end else begin
      ar_q.push_back(addr);
      if (err_region(addr)) r.err = 1'b1;
      else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(mem_m[b + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        r.rdata = v[31:0];
      end
    end
    resp_q.push_back(r);
  endtask

  // ---------------- AXI-lite slave ----------------
  bit          fast = 1'b1;
  bit          hold_r = 1'b0;
  int          aw_stall = 0;
  rd_t         rpend[$];
  logic [1:0]  bpend[$];
  bit          aw_got, w_got, r_hs, b_hs;
  logic [31:0] aw_a, w_d;
  logic [3:0]  w_s;
  bit          ar_wait, aw_wait, w_wait, ar_hs_prev, aw_hs_prev, w_hs_prev;
  logic [31:0] ar_prev, aw_prev, wd_prev;
  logic [3:0]  ws_prev;

  initial begin
    wr_t e;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = 0; rresp = 0; bresp = 0;
    aw_got = 0; w_got = 0; r_hs = 0; b_hs = 0;
    ar_wait = 0; aw_wait = 0; w_wait = 0; ar_hs_prev = 0; aw_hs_prev = 0; w_hs_prev = 0;
    forever begin
      @(negedge clk);
      r_hs = 0;
      b_hs = 0;
      if (rst) begin
        rpend.delete(); bpend.delete();
        aw_got = 0; w_got = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; ar_hs_prev = 0; aw_hs_prev = 0; w_hs_prev = 0;
      end else begin
        if (ar_wait) check("ar_hold", {arvalid, araddr}, {1'b1, ar_prev});
        if (aw_wait) check("aw_hold", {awvalid, awaddr}, {1'b1, aw_prev});
        if (w_wait)  check("w_hold", {wvalid, wstrb, wdata}, {1'b1, ws_prev, wd_prev});
        if (ar_hs_prev) check("ar_drop", arvalid, 0);
        if (aw_hs_prev) check("aw_drop", awvalid, 0);
        if (w_hs_prev)  check("w_drop", wvalid, 0);
        ar_hs_prev = arvalid && arready; ar_wait = arvalid && !arready; ar_prev = araddr;
        aw_hs_prev = awvalid && awready; aw_wait = awvalid && !awready; aw_prev = awaddr;
        w_hs_prev  = wvalid && wready;   w_wait  = wvalid && !wready;
        wd_prev = wdata; ws_prev = wstrb;
        if (aw_stall > 0 && awvalid) aw_stall--;

        if (arvalid && arready) begin
          if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
          else check("araddr", araddr, ar_q.pop_front());
          rpend.push_back('{mem_s[araddr[5:2]], err_region(araddr) ? 2'b10 : 2'b00});
        end
        if (rvalid && rready) begin void'(rpend.pop_front()); r_hs = 1; end
        if (awvalid && awready) begin aw_got = 1; aw_a = awaddr; end
        if (wvalid && wready) begin w_got = 1; w_d = wdata; w_s = wstrb; end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0;
          if (wr_q.size() == 0) check("aw_unexpected", 1, 0);
          else begin
            e = wr_q.pop_front();
            check("awaddr", aw_a, e.addr);
            check("wdata", w_d, e.data);
            check("wstrb", w_s, e.strb);
          end
          if (!err_region(aw_a))
            for (int i = 0; i < 4; i++) if (w_s[i]) mem_s[aw_a[5:2]][i*8 +: 8] = w_d[i*8 +: 8];
          bpend.push_back(err_region(aw_a) ? 2'b10 : 2'b00);
        end
        if (bvalid && bready) begin void'(bpend.pop_front()); b_hs = 1; end
      end

      @(posedge clk);
      #1;
      arready = fast || ($urandom % 3 != 0);
      awready = (aw_stall > 0) ? 1'b0 : (fast || ($urandom % 3 != 0));
      wready  = fast || ($urandom % 3 != 0);
      if (rst || r_hs) rvalid = 0;
      if (rst || b_hs) bvalid = 0;
      if (!rst && !rvalid && rpend.size() > 0 && !hold_r && (fast || $urandom % 2 == 0)) begin
        rvalid = 1; rdata = rpend[0].d; rresp = rpend[0].resp;
      end
      if (!rst && !bvalid && bpend.size() > 0 && (fast || $urandom % 2 == 0)) begin
        bvalid = 1; bresp = bpend[0];
      end
    end
  end

  // ---------------- response ready driver and monitor ----------------
  bit          rr_hold = 1'b0;
  bit          mon_wait;
  logic [32:0] mon_prev;

  initial begin
    resp_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      resp_ready = rr_hold ? 1'b0 : ($urandom % 3 != 0);
    end
  end

  initial begin
    resp_t e;
    mon_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) mon_wait = 0;
      else begin
        if (mon_wait) begin
          check("resp_valid_hold", resp_valid, 1);
          check("resp_payload_hold", {resp_err, resp_rdata}, mon_prev);
        end
        if (resp_valid) begin
          check("req_ready_in_resp", req_ready, 0);
          if (resp_ready) begin
            if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
            else begin
              e = resp_q.pop_front();
              check("resp_rdata", resp_rdata, e.rdata);
              check("resp_err", resp_err, e.err);
            end
            mon_wait = 0;
          end else begin
            mon_wait = 1;
            mon_prev = {resp_err, resp_rdata};
          end
        end else mon_wait = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int size, input logic uns);
    int t = 0;
    @(posedge clk);
    #1;
    req_we = we; req_addr = addr; req_wdata = wd; req_size = size[1:0]; req_unsigned = uns;
    req_valid = 1;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready && t < 300);
    if (!req_ready) begin
      check("req_accept_timeout", 1, 0);
      req_valid = 0;
      return;
    end
    model_request(we, addr, wd, size, uns);
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((resp_q.size() != 0 || !req_ready) && t < 500);
    if (resp_q.size() != 0 || !req_ready) check("idle_timeout", 1, 0);
  endtask

  task automatic check_latency(input string name, input int exp);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!resp_valid && t < 50);
    check(name, t, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1);
  end

  initial begin
    int sz;
    logic [31:0] a;
    rst = 1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 0);
    check("rst_resp", {resp_err, resp_rdata}, 0);
    check("rst_regs", {araddr, wdata, wstrb}, 0);
    @(negedge clk);
    #2 rst = 0;

    // Store word, then store byte into lane 3.
    do_req(1, 32'h8000_0000, 32'hDEAD_BEEF, 2, 0);
    check_latency("store_latency", 3);
    wait_idle();
    do_req(1, 32'h8000_0003, 32'h0000_00A5, 0, 0);
    wait_idle();
    check("mem_after_stores", mem_s[0], 32'hA5AD_BEEF);

    // Signed and unsigned byte loads from lane 2.
    set_word(0, 32'h1280_FF34);
    do_req(0, 32'h8000_0002, 0, 0, 0);
    check_latency("load_latency", 3);
    wait_idle();
    do_req(0, 32'h8000_0002, 0, 0, 1);
    wait_idle();

    // Misaligned half load and word store: error, no bus traffic.
    do_req(0, 32'h8000_0001, 0, 1, 0);
    check_latency("misaligned_latency", 1);
    wait_idle();
    do_req(1, 32'h8000_0002, 32'h1234_5678, 2, 0);
    wait_idle();

    // AW stalled three cycles with W ready, then a load answered with SLVERR.
    aw_stall = 3;
    do_req(1, 32'h8000_0008, 32'hCAFE_F00D, 2, 0);
    wait_idle();
    check("aw_stall_consumed", aw_stall, 0);
    do_req(0, 32'h8000_1004, 0, 2, 0);
    wait_idle();

    // Response back-pressure for four cycles.
    rr_hold = 1;
    do_req(0, 32'h8000_0004, 0, 2, 0);
    check_latency("bp_resp_arrives", 3);
    repeat (4) begin
      @(negedge clk);
      check("bp_resp_valid", resp_valid, 1);
      check("bp_req_ready", req_ready, 0);
    end
    rr_hold = 0;
    wait_idle();

    // Asynchronous reset while waiting for read data.
    hold_r = 1;
    do_req(0, 32'h8000_000C, 0, 2, 0);
    begin
      int t = 0;
      while (!rready && t < 50) begin @(negedge clk); t++; end
      check("reach_rd_d", rready, 1);
    end
    #2 rst = 1;
    #1;
    check("arst_valids", {arvalid, rready, resp_valid}, 0);
    check("arst_idle", req_ready, 1);
    resp_q.delete(); ar_q.delete(); wr_q.delete();
    hold_r = 0;
    repeat (2) @(negedge clk);
    #2 rst = 0;

    // Randomized traffic with a slow, random slave.
    fast = 0;
    for (int k = 0; k < 300; k++) begin
      sz = ($urandom % 10 == 0) ? 3 : int'($urandom % 3);
      a = 32'h8000_0000 | ($urandom % 64) | (($urandom % 8 == 0) ? 32'h1000 : 32'h0);
      if ($urandom % 4 == 0) a[1:0] = 2'b00;
      do_req($urandom % 2, a, $urandom, sz, $urandom % 2);
      repeat ($urandom % 3) @(posedge clk);
    end
    wait_idle();
    check("final_queues_empty", ar_q.size() + wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
